// File: rtl/noc_pkt_gen.sv
// ============================================================================
// Module   : noc_pkt_gen
// Purpose  : NoC traffic generator. Walks a destination table, skips its own
//            node id and offers timestamped packets with a programmable gap.
//            Define PKT_GEN_LFSR_EN to add LFSR-driven random destinations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_pkt_gen #(
    parameter int ROUTER_NUM = 9,
    parameter int ID_SIZE    = 4,
    parameter int TIME_SIZE  = 10,
    parameter int DATA_SIZE  = 20,
    parameter int CNT_SIZE   = 8,
    parameter int RATE_SIZE  = 4,
    localparam int PKT_W     = 2*ID_SIZE + TIME_SIZE + DATA_SIZE + 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          flush,
    input  logic [ID_SIZE-1:0]            self_id,
    input  logic [CNT_SIZE-1:0]           send_num,
    input  logic [RATE_SIZE-1:0]          rate,
    input  logic [1:0]                    mode,
    input  logic [ROUTER_NUM*ID_SIZE-1:0] dst_seq,
    input  logic                          pkt_ready,
    output logic                          pkt_valid,
    output logic [PKT_W-1:0]              pkt_data,
    output logic [CNT_SIZE-1:0]           sent_cnt,
    output logic                          task_send_finish_flag
);

    localparam int PTR_W = (ROUTER_NUM > 1) ? $clog2(ROUTER_NUM) : 1;
    localparam logic [1:0] C_TYPE = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEL  = 3'd1,
        S_SEND = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       w_ptr_inc;
    logic [PTR_W-1:0]       w_idx;
    logic [CNT_SIZE-1:0]    r_sent_cnt;
    logic [TIME_SIZE-1:0]   r_time;
    logic [RATE_SIZE-1:0]   r_gap;
    logic [PKT_W-1:0]       r_pkt;
    logic [ID_SIZE-1:0]     w_dst;
    logic                   w_is_self;
    logic                   w_quota_met;
    logic                   w_last;

    assign w_ptr_inc   = (r_ptr == PTR_W'(ROUTER_NUM - 1)) ? '0 : r_ptr + PTR_W'(1);
    assign w_dst       = dst_seq[int'(w_idx)*ID_SIZE +: ID_SIZE];
    assign w_is_self   = (w_dst == self_id);
    assign w_quota_met = (r_sent_cnt >= send_num);
    // Widened by one bit so a full-scale count cannot wrap in the compare.
    assign w_last      = (({1'b0, r_sent_cnt} + (CNT_SIZE+1)'(1)) >= {1'b0, send_num});

`ifdef PKT_GEN_LFSR_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_mod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_lfsr_mod = r_lfsr % 16'(ROUTER_NUM);
    assign w_idx      = (mode == 2'b10) ? PTR_W'(w_lfsr_mod) : r_ptr;
`else
    assign w_idx      = r_ptr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (flush) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        w_next = (send_num == '0) ? S_DONE : S_SEL;
                    end
                end
                S_SEL: begin
                    if (enable) begin
                        if (w_quota_met) begin
                            w_next = S_DONE;
                        end else if (!w_is_self) begin
                            w_next = S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    if (pkt_ready) begin
                        if (w_last) begin
                            w_next = S_DONE;
                        end else if (rate == '0) begin
                            w_next = S_SEL;
                        end else begin
                            w_next = S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (enable && (r_gap == '0)) begin
                        w_next = S_SEL;
                    end
                end
                S_DONE:  w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Timestamp base runs regardless of flush so packet times stay monotonic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_time <= '0;
        end else begin
            r_time <= r_time + TIME_SIZE'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_sent_cnt <= '0;
            r_gap      <= '0;
            r_pkt      <= '0;
        end else if (flush) begin
            r_ptr      <= '0;
            r_sent_cnt <= '0;
            r_gap      <= '0;
        end else begin
            case (r_state)
                S_SEL: begin
                    if (enable && !w_quota_met) begin
                        if (w_is_self) begin
                            r_ptr <= w_ptr_inc;
                        end else begin
                            r_pkt <= {self_id, w_dst, r_time, DATA_SIZE'(r_sent_cnt), C_TYPE};
                        end
                    end
                end
                S_SEND: begin
                    if (pkt_ready) begin
                        r_sent_cnt <= r_sent_cnt + CNT_SIZE'(1);
                        r_ptr      <= (mode == 2'b01) ? '0 : w_ptr_inc;
                        r_gap      <= rate - RATE_SIZE'(1);
                    end
                end
                S_GAP: begin
                    if (enable && (r_gap != '0)) begin
                        r_gap <= r_gap - RATE_SIZE'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pkt_valid             = (r_state == S_SEND);
    assign task_send_finish_flag = (r_state == S_DONE);
    assign pkt_data              = r_pkt;
    assign sent_cnt              = r_sent_cnt;

endmodule

`default_nettype wire

// File: tb/tb_noc_pkt_gen.sv
// ============================================================================
// Module   : tb_noc_pkt_gen
// Purpose  : Self-checking bench for noc_pkt_gen (expected-packet model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_pkt_gen;

    localparam int RN = 9;
    localparam int IDS = 4;
    localparam int TS = 10;
    localparam int DS = 20;
    localparam int CS = 8;
    localparam int RS = 4;
    localparam int PW = 2*IDS + TS + DS + 2;
    localparam logic [35:0] C_SEQ = 36'h0_a9865421;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              flush = 1'b0;
    logic [IDS-1:0]    self_id = '0;
    logic [CS-1:0]     send_num = '0;
    logic [RS-1:0]     rate = '0;
    logic [1:0]        mode = '0;
    logic [RN*IDS-1:0] dst_seq = '0;
    logic              pkt_ready = 1'b0;
    logic              pkt_valid;
    logic [PW-1:0]     pkt_data;
    logic [CS-1:0]     sent_cnt;
    logic              task_send_finish_flag;

    noc_pkt_gen dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .enable                (enable),
        .flush                 (flush),
        .self_id               (self_id),
        .send_num              (send_num),
        .rate                  (rate),
        .mode                  (mode),
        .dst_seq               (dst_seq),
        .pkt_ready             (pkt_ready),
        .pkt_valid             (pkt_valid),
        .pkt_data              (pkt_data),
        .sent_cnt              (sent_cnt),
        .task_send_finish_flag (task_send_finish_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Expected-traffic model: the ordered list of non-self destinations.
    logic [IDS-1:0] nonself[$];
    int             m_cnt = 0;
    int             m_num = 0;
    logic [1:0]     m_mode = '0;
    logic [IDS-1:0] m_self = '0;
    bit             m_done_due = 1'b0;
    bit             m_hold = 1'b0;
    logic [PW-1:0]  m_held = '0;
    int             cyc = 0;
    int             valid_cycles = 0;
    logic [IDS-1:0] acc_dst[$];
    int             acc_time[$];
    int             acc_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [IDS-1:0] exp_dst();
        if (m_mode == 2'b01) return nonself[0];
        return nonself[m_cnt % nonself.size()];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic [IDS-1:0] f_src, f_dst;
            logic [TS-1:0]  f_tm;
            logic [DS-1:0]  f_dat;
            logic [1:0]     f_typ;
            {f_src, f_dst, f_tm, f_dat, f_typ} = pkt_data;
            chk("sent_cnt", 64'(sent_cnt), 64'(CS'(m_cnt)));
            if (m_done_due) begin
                chk("flag_done", 64'(task_send_finish_flag), 64'd1);
                chk("valid_in_done", 64'(pkt_valid), 64'd0);
            end else if (m_cnt < m_num) begin
                chk("flag_early", 64'(task_send_finish_flag), 64'd0);
            end
            if (pkt_valid) begin
                valid_cycles++;
                if (nonself.size() == 0 || m_cnt >= m_num) begin
                    chk("unexpected_valid", 64'(pkt_valid), 64'd0);
                end else begin
                    if (m_hold) begin
                        chk("hold_stable", 64'(pkt_data), 64'(m_held));
                    end else begin
                        chk("timestamp", 64'(f_tm), 64'(TS'(cyc - 1)));
                        m_held = pkt_data;
                        m_hold = 1'b1;
                    end
                    chk("src", 64'(f_src), 64'(m_self));
                    chk("type", 64'(f_typ), 64'd1);
                    chk("data", 64'(f_dat), 64'(DS'(m_cnt)));
`ifdef PKT_GEN_LFSR_EN
                    if (m_mode == 2'b10) chk("dst_not_self", 64'(f_dst == m_self), 64'd0);
                    else
`endif
                    chk("dst", 64'(f_dst), 64'(exp_dst()));
                end
                if (pkt_ready) begin
                    acc_dst.push_back(f_dst);
                    acc_time.push_back(int'(f_tm));
                    acc_cyc.push_back(cyc);
                    m_cnt++;
                    m_hold = 1'b0;
                    if (m_cnt >= m_num) m_done_due = 1'b1;
                end
            end else begin
                if (m_hold) chk("valid_dropped", 64'(pkt_valid), 64'd1);
                m_hold = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic model_clear();
        m_cnt = 0;
        m_done_due = 1'b0;
        m_hold = 1'b0;
        acc_dst.delete();
        acc_time.delete();
        acc_cyc.delete();
    endtask

    task automatic set_task(input logic [IDS-1:0] s, input logic [35:0] seq, input int num,
                            input logic [RS-1:0] r, input logic [1:0] md);
        self_id  = s;
        dst_seq  = seq;
        send_num = CS'(num);
        rate     = r;
        mode     = md;
        m_self   = s;
        m_num    = num;
        m_mode   = md;
        nonself.delete();
        for (int k = 0; k < RN; k++) begin
            logic [IDS-1:0] e;
            e = seq[k*IDS +: IDS];
            if (e != s) nonself.push_back(e);
        end
        model_clear();
    endtask

    task automatic do_flush();
        flush  = 1'b1;
        enable = 1'b0;
        tick();
        flush  = 1'b0;
        model_clear();
    endtask

    task automatic run_until_done(input int budget);
        int n = 0;
        while (!(m_done_due && task_send_finish_flag) && n < budget) begin
            tick();
            n++;
        end
        chk("done_timeout", 64'(task_send_finish_flag), 64'd1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!pkt_valid && n < 50) begin
            tick();
            n++;
        end
        chk("valid_timeout", 64'(pkt_valid), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IDS-1:0] exp_rr [8] = '{4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'ha};
        logic [PW-1:0]  cap;
        int             vc0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(pkt_valid), 64'd0);
        chk("rst_data", 64'(pkt_data), 64'd0);
        chk("rst_cnt", 64'(sent_cnt), 64'd0);
        chk("rst_flag", 64'(task_send_finish_flag), 64'd0);
        tick();
        rst_n = 1'b1;

        // Round-robin, rate 0, always ready
        set_task(4'h0, C_SEQ, 8, 4'd0, 2'b00);
        pkt_ready = 1'b1;
        enable = 1'b1;
        run_until_done(200);
        chk("rr_count", 64'(acc_dst.size()), 64'd8);
        for (int i = 0; i < 8 && i < acc_dst.size(); i++) chk("rr_dst_lit", 64'(acc_dst[i]), 64'(exp_rr[i]));
        for (int i = 1; i < acc_cyc.size(); i++) chk("rr_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd2);
        do_flush();

        // Backpressure
        set_task(4'h0, C_SEQ, 2, 4'd0, 2'b00);
        pkt_ready = 1'b0;
        enable = 1'b1;
        wait_valid();
        cap = pkt_data;
        repeat (5) begin
            tick();
            chk("bp_data", 64'(pkt_data), 64'(cap));
            chk("bp_cnt", 64'(sent_cnt), 64'd0);
        end
        pkt_ready = 1'b1;
        run_until_done(50);
        chk("bp_dst0", 64'(acc_dst.size() > 0 ? acc_dst[0] : 4'hf), 64'h1);
        do_flush();

        // Gap of 3 idle cycles
        set_task(4'h0, C_SEQ, 3, 4'd3, 2'b00);
        enable = 1'b1;
        run_until_done(100);
        chk("rate_count", 64'(acc_time.size()), 64'd3);
        for (int i = 1; i < acc_time.size(); i++) begin
            chk("rate_tdiff", 64'(TS'(acc_time[i] - acc_time[i-1])), 64'd5);
            chk("rate_cdiff", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd5);
        end
        do_flush();

        // Fixed mode, entry 0 is self so entry 1 (=2) is always chosen
        set_task(4'h0, 36'h0_a9865420, 4, 4'd1, 2'b01);
        enable = 1'b1;
        run_until_done(100);
        for (int i = 0; i < acc_dst.size(); i++) chk("fixed_dst", 64'(acc_dst[i]), 64'h2);
        do_flush();

`ifdef PKT_GEN_LFSR_EN
        set_task(4'h5, C_SEQ, 200, 4'd0, 2'b10);
        enable = 1'b1;
        run_until_done(4000);
        chk("lfsr_count", 64'(acc_dst.size()), 64'd200);
`else
        // Mode 10 follows round-robin; entry 8 (=0) reachable since self is 2
        set_task(4'h2, C_SEQ, 9, 4'd0, 2'b10);
        enable = 1'b1;
        run_until_done(100);
        chk("m10_last_dst", 64'(acc_dst.size() > 8 ? acc_dst[7] : 4'hf), 64'h0);
`endif
        do_flush();

        // send_num = 0: flag one cycle after enable, never valid
        set_task(4'h0, C_SEQ, 0, 4'd0, 2'b00);
        enable = 1'b1;
        tick();
        chk("zero_flag", 64'(task_send_finish_flag), 64'd1);
        chk("zero_valid", 64'(pkt_valid), 64'd0);
        m_done_due = 1'b1;
        tick();
        do_flush();

        // Every entry is self: stays in selection forever
        set_task(4'h3, {9{4'h3}}, 5, 4'd0, 2'b00);
        enable = 1'b1;
        vc0 = valid_cycles;
        repeat (100) tick();
        chk("allself_valid", 64'(valid_cycles - vc0), 64'd0);
        chk("allself_cnt", 64'(sent_cnt), 64'd0);
        chk("allself_flag", 64'(task_send_finish_flag), 64'd0);
        do_flush();

        // Flush during the accept of the fifth packet
        set_task(4'h0, C_SEQ, 8, 4'd0, 2'b00);
        enable = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (!(pkt_valid && sent_cnt == CS'(4)) && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("flush_reach", 64'(sent_cnt), 64'd4);
        end
        flush = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
        enable = 1'b0;
        model_clear();
        chk("flush_cnt", 64'(sent_cnt), 64'd0);
        chk("flush_valid", 64'(pkt_valid), 64'd0);
        tick();
        set_task(4'h0, C_SEQ, 3, 4'd0, 2'b00);
        enable = 1'b1;
        run_until_done(50);
        chk("flush_restart_dst", 64'(acc_dst.size() > 0 ? acc_dst[0] : 4'hf), 64'h1);
        do_flush();

        // Asynchronous reset while a packet is offered
        set_task(4'h0, C_SEQ, 3, 4'd0, 2'b00);
        pkt_ready = 1'b0;
        enable = 1'b1;
        wait_valid();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(pkt_valid), 64'd0);
        chk("arst_data", 64'(pkt_data), 64'd0);
        chk("arst_cnt", 64'(sent_cnt), 64'd0);
        chk("arst_flag", 64'(task_send_finish_flag), 64'd0);
        enable = 1'b0;
        pkt_ready = 1'b1;
        model_clear();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst_idle_valid", 64'(pkt_valid), 64'd0);
        enable = 1'b1;
        run_until_done(50);
        chk("arst_restart_dst", 64'(acc_dst.size() > 0 ? acc_dst[0] : 4'hf), 64'h1);
        do_flush();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/noc_pkt_gen.md
NOC_PKT_GEN -- requirements
Module: noc_pkt_gen

Interface
REQ-001 Parameters (name, default, meaning), SHALL be:
- ROUTER_NUM, 9: dst_seq entries.
- ID_SIZE, 4: node id width.
- TIME_SIZE, 10: timestamp width.
- DATA_SIZE, 20: payload width.
- CNT_SIZE, 8: packet counter width.
- RATE_SIZE, 4: gap field width.
- PKT_W = 2*ID_SIZE+TIME_SIZE+DATA_SIZE+2: derived, 40 at defaults.
REQ-002 Ports (name, direction, width, meaning), SHALL be:
- clk  in  1  single clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  run/pause.
- flush  in  1  synchronous clear.
- self_id  in  ID_SIZE  own node id.
- send_num  in  CNT_SIZE  packets to send.
- rate  in  RATE_SIZE  idle cycles between packets.
- mode  in  2  00 round-robin, 01 fixed, 10 random, 11 as 00.
- dst_seq  in  ROUTER_NUM*ID_SIZE  entry k at [k*ID_SIZE +: ID_SIZE].
- pkt_ready  in  1  router accepts.
- pkt_valid  out  1  packet offered.
- pkt_data  out  PKT_W  packet.
- sent_cnt  out  CNT_SIZE  accepted packets.
- task_send_finish_flag  out  1  task done.
REQ-003 pkt_data layout, MSB to LSB, SHALL be: src = self_id; dst; time[TIME_SIZE]; data[DATA_SIZE] = zero-extended sent_cnt at offer time; type[2] = 2'b01.

Function
REQ-004 The FSM SHALL have states IDLE, SEL, SEND, GAP, DONE.
REQ-005 IDLE SHALL go to DONE if enable=1 and send_num=0, to SEL if enable=1 and send_num>0, and hold otherwise.
REQ-006 SEL SHALL select dst from pointer ptr (0..ROUTER_NUM-1); if dst==self_id it SHALL advance ptr and stay in SEL one cycle per skipped entry, else it SHALL load pkt_data and go to SEND.
REQ-007 In SEND, pkt_valid SHALL be 1 and pkt_data stable until the cycle with pkt_ready=1; once asserted, valid SHALL NOT drop for enable=0.
REQ-008 On accept, sent_cnt SHALL increment; ptr SHALL advance (mode 00) or hold at 0 (mode 01); the FSM SHALL go to DONE if sent_cnt+1==send_num, else to GAP.
REQ-009 GAP SHALL last exactly rate cycles (rate=0 means zero cycles: SEND goes directly to SEL) and SHALL hold while enable=0.
REQ-010 SEL SHALL hold while enable=0.
REQ-011 ptr SHALL wrap from ROUTER_NUM-1 to 0.
REQ-012 A free-running time counter SHALL increment every cycle from reset, wrapping mod 2^TIME_SIZE; time SHALL be its value in the SEL->SEND cycle.
REQ-013 DONE SHALL assert task_send_finish_flag=1 and pkt_valid=0, and SHALL hold until flush or reset.
REQ-014 flush SHALL take precedence over all events, including an accept in the same cycle: next state IDLE; ptr, sent_cnt and flag cleared; pkt_valid=0; the time counter is not cleared.
REQ-015 If all ROUTER_NUM entries equal self_id, the FSM SHALL cycle in SEL indefinitely with pkt_valid=0 and no count.
REQ-016 A send_num or mode change mid-task SHALL take effect at the next SEL/DONE evaluation; sent_cnt>=send_num at accept SHALL go to DONE.

Reset
REQ-017 While rst_n=0, all of the following SHALL be 0 and the state SHALL be IDLE: pkt_valid, pkt_data, sent_cnt, task_send_finish_flag, ptr, time counter, gap counter.
REQ-018 Reset deassertion mid-task SHALL restart from IDLE with no packet replay.

Configuration
REQ-019 With PKT_GEN_LFSR_EN defined, mode 10 SHALL draw ptr = LFSR mod ROUTER_NUM in each SEL cycle from a 16-bit LFSR (x^16+x^14+x^13+x^11+1) that is reset to 16'hACE1 and steps every cycle; self-id skipping applies.
REQ-020 Without PKT_GEN_LFSR_EN, no LFSR SHALL be built and mode 10 SHALL behave as mode 00.

Verification
REQ-021 Round-robin: self_id=0, dst_seq=36'h0_a9865421, send_num=8, rate=0, pkt_ready=1 -> dst sequence 1,2,4,5,6,8,9,a; data 0..7; flag after 8th accept; entry 8 never sent.
REQ-022 Backpressure: pkt_ready=0 for 5 cycles after valid -> pkt_data unchanged across the 5 cycles; sent_cnt unchanged until ready.
REQ-023 Rate: rate=3, send_num=3, ready=1 -> valid asserted with 3 idle cycles between accepts; timestamps differ by 5 (SEL+SEND+3 GAP).
REQ-024 Edge cases: send_num=0 -> flag one cycle after enable with no valid; all entries = self_id -> no valid for 100 cycles.
REQ-025 Flush at accept cycle with sent_cnt=4 -> sent_cnt=0, IDLE next cycle; re-enable restarts from ptr=0.
REQ-026 Async reset mid-SEND -> outputs 0 immediately, before the next clk edge; with PKT_GEN_LFSR_EN, mode 10 over 200 packets -> no dst==self_id.
